// File: rtl/dac_pkg.sv
// Shared types for the DAC playback path: sample width, sample type and FSM encoding.
package dac_pkg;

    localparam int unsigned SAMPLE_W = 14;

    typedef logic [SAMPLE_W-1:0] dac_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } dac_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers, synchronous flush and a combinational head.
module sync_fifo #(
    parameter int unsigned W  = 14,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_c,
    output logic [AW:0]   level_c,
    output logic          full_c,
    output logic          empty_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign level_c = wr_ptr_q - rd_ptr_q;
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    // Flush wins over any same-cycle push or pop.
    assign do_push = push_i && !full_c && !flush_i;
    assign do_pop  = pop_i && !empty_c && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dac_playback_fifo.sv
// Paced DAC playback buffer: FIFO plus IDLE/PRIME/RUN sequencer, rate divider and
// registered DAC data/strobe with sticky underrun reporting.
module dac_playback_fifo
    import dac_pkg::*;
#(
    parameter int unsigned AW    = 6,
    parameter int unsigned DIV_W = 16
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                enable,
    input  logic                flush,
    input  logic [DIV_W-1:0]    rate_div,
    input  logic [AW:0]         prime_lvl,
    input  logic                underrun_clr,
    output logic [AW:0]         level,
    output logic                underrun,
    output logic [1:0]          state_o,
    output logic [SAMPLE_W-1:0] dac_ch1_data,
    output logic                dac_ch1_wrt,
    output logic                dac_ch1_clk
);

    dac_state_e  state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    dac_sample_t data_q, data_d;
    logic        wrt_q, wrt_d;
    logic        underrun_q, underrun_d;
    logic        underrun_set;
    logic        pop;

    dac_sample_t fifo_head;
    logic [AW:0] fifo_level;
    logic        fifo_full;
    logic        fifo_empty;

    sync_fifo #(
        .W  (SAMPLE_W),
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push_i  (s_valid && s_ready),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (s_data),
        .head_c  (fifo_head),
        .level_c (fifo_level),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    assign s_ready      = !fifo_full;
    assign level        = fifo_level;
    assign underrun     = underrun_q;
    assign state_o      = state_q;
    assign dac_ch1_data = data_q;
    assign dac_ch1_wrt  = wrt_q;
    assign dac_ch1_clk  = clk;

    // Sequencer: disable and flush override the per-state behaviour.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        wrt_d        = 1'b0;
        underrun_set = 1'b0;
        pop          = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (flush) begin
            state_d = ST_PRIME;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    cnt_d = '0;
                    if ((fifo_level >= prime_lvl) || fifo_full) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q == rate_div) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            data_d = fifo_head;
                            wrt_d  = 1'b1;
                        end else begin
                            underrun_set = 1'b1;
                            state_d      = ST_PRIME;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A set in the same cycle as a clear leaves the flag raised.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_set)      underrun_d = 1'b1;
        else if (underrun_clr) underrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            wrt_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            wrt_q      <= wrt_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dac_playback_fifo.sv
// Directed bench for dac_playback_fifo: priming, pacing, underrun, full, flush and reset.
module tb_dac_playback_fifo;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] s_data;
    logic        enable;
    logic        flush;
    logic [15:0] rate_div;
    logic [6:0]  prime_lvl;
    logic        underrun_clr;
    logic [6:0]  level;
    logic        underrun;
    logic [1:0]  state_o;
    logic [13:0] dac_ch1_data;
    logic        dac_ch1_wrt;
    logic        dac_ch1_clk;

    int checks = 0;
    int errors = 0;

    dac_playback_fifo dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .enable       (enable),
        .flush        (flush),
        .rate_div     (rate_div),
        .prime_lvl    (prime_lvl),
        .underrun_clr (underrun_clr),
        .level        (level),
        .underrun     (underrun),
        .state_o      (state_o),
        .dac_ch1_data (dac_ch1_data),
        .dac_ch1_wrt  (dac_ch1_wrt),
        .dac_ch1_clk  (dac_ch1_clk)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn      = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        enable       = 1'b0;
        flush        = 1'b0;
        rate_div     = '0;
        prime_lvl    = '0;
        underrun_clr = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_level",    32'(level), 0);
        chk("rst_s_ready",  32'(s_ready), 1);
        chk("rst_data",     32'(dac_ch1_data), 0);
        chk("rst_wrt",      32'(dac_ch1_wrt), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_state",    32'(state_o), 0);
        aresetn = 1'b1;
        step();

        // Prime with 1..4, rate_div=3: strobes every 4 cycles
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data  = 14'(i);
            step();
        end
        s_valid = 1'b0;
        chk("t1_level4", 32'(level), 4);
        prime_lvl = 7'd4;
        rate_div  = 16'd3;
        enable    = 1'b1;
        step();
        chk("t1_prime", 32'(state_o), 1);
        step();
        chk("t1_run", 32'(state_o), 2);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) begin
                step();
                chk("t1_nowrt", 32'(dac_ch1_wrt), 0);
            end
            step();
            chk("t1_wrt",   32'(dac_ch1_wrt), 1);
            chk("t1_data",  32'(dac_ch1_data), 32'(k));
            chk("t1_level", 32'(level), 32'(4 - k));
        end

        // Fifth tick underruns
        repeat (3) begin
            step();
            chk("t2_nowrt", 32'(dac_ch1_wrt), 0);
        end
        step();
        chk("t2_underrun", 32'(underrun), 1);
        chk("t2_state",    32'(state_o), 1);
        chk("t2_data",     32'(dac_ch1_data), 4);
        chk("t2_wrt",      32'(dac_ch1_wrt), 0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("t2_clr", 32'(underrun), 0);

        // Fill to 64 while disabled, 65th rejected, then drain at full rate
        enable = 1'b0;
        step();
        chk("t3_idle", 32'(state_o), 0);
        for (int i = 0; i < 64; i++) begin
            s_valid = 1'b1;
            s_data  = 14'(32'h100 + i);
            step();
        end
        chk("t3_level64", 32'(level), 64);
        chk("t3_full",    32'(s_ready), 0);
        s_data = 14'h3FFF;
        step();
        s_valid = 1'b0;
        chk("t3_level65", 32'(level), 64);
        rate_div  = 16'd0;
        prime_lvl = 7'd64;
        enable    = 1'b1;
        step();
        chk("t3_prime", 32'(state_o), 1);
        step();
        chk("t3_run", 32'(state_o), 2);
        for (int i = 0; i < 64; i++) begin
            step();
            chk("t3_wrt",  32'(dac_ch1_wrt), 1);
            chk("t3_data", 32'(dac_ch1_data), 32'h100 + 32'(i));
        end
        chk("t3_empty", 32'(level), 0);
        step();
        chk("t3_underrun", 32'(underrun), 1);
        chk("t3_nowrt",    32'(dac_ch1_wrt), 0);
        chk("t3_state",    32'(state_o), 1);
        chk("t3_hold",     32'(dac_ch1_data), 32'h13F);

        // Streaming at rate_div=0 with level 10 and continuous pushes
        enable       = 1'b0;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("t4_idle",   32'(state_o), 0);
        chk("t4_clr",    32'(underrun), 0);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 14'(32'h200 + i);
            step();
        end
        s_valid   = 1'b0;
        prime_lvl = 7'd10;
        rate_div  = 16'd0;
        enable    = 1'b1;
        step();
        chk("t4_prime", 32'(state_o), 1);
        step();
        chk("t4_run",   32'(state_o), 2);
        chk("t4_level", 32'(level), 10);
        s_valid = 1'b1;
        s_data  = 14'h20A;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_wrt",    32'(dac_ch1_wrt), 1);
            chk("t4_data",   32'(dac_ch1_data), 32'h200 + 32'(i));
            chk("t4_lvl",    32'(level), 10);
            s_data = 14'(32'h20B + i);
        end
        chk("t4_no_underrun", 32'(underrun), 0);

        // Build level to 20 with slow rate, then flush with a same-cycle push
        rate_div = 16'd100;
        s_data   = 14'h300;
        for (int i = 0; i < 10; i++) begin
            step();
            s_data = 14'(32'h301 + i);
        end
        chk("t5_level20", 32'(level), 20);
        flush  = 1'b1;
        s_data = 14'h3FF;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("t5_level0", 32'(level), 0);
        chk("t5_state",  32'(state_o), 1);
        chk("t5_data",   32'(dac_ch1_data), 32'h213);
        chk("t5_wrt",    32'(dac_ch1_wrt), 0);
        chk("t5_underrun", 32'(underrun), 0);

        // Reset between a tick and its strobe
        enable = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 14'(32'h0AA + 32'(i) * 32'h11);
            step();
        end
        s_valid   = 1'b0;
        prime_lvl = 7'd1;
        rate_div  = 16'd0;
        enable    = 1'b1;
        step();
        step();
        chk("t6_run", 32'(state_o), 2);
        aresetn = 1'b0;
        #2;
        chk("t6_state",    32'(state_o), 0);
        chk("t6_level",    32'(level), 0);
        chk("t6_data",     32'(dac_ch1_data), 0);
        chk("t6_wrt",      32'(dac_ch1_wrt), 0);
        chk("t6_s_ready",  32'(s_ready), 1);
        step();
        chk("t6_wrt_rst",  32'(dac_ch1_wrt), 0);
        chk("t6_underrun", 32'(underrun), 0);
        enable  = 1'b0;
        aresetn = 1'b1;
        repeat (3) begin
            step();
            chk("t6_stay_idle", 32'(state_o), 0);
        end
        enable = 1'b1;
        step();
        chk("t6_prime", 32'(state_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
